// File: rtl/data_sync_pkg.sv
// Shared definitions for both ends of the multi-bit data synchronizer.
package data_sync_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ASSERT  = 2'd2,
    RELEASE = 2'd3
  } sync_state_t;

  localparam int DEFAULT_NUM_STAGES = 2;

endpackage

// File: rtl/data_sync_src_if.sv
// Local word handshake plus the crossing bus/enable and the returning acknowledge.
interface data_sync_src_if #(
  parameter int BUS_WIDTH = 8
);

  logic [BUS_WIDTH-1:0] SRC_DATA;
  logic                 SRC_VALID;
  logic                 SRC_READY;
  logic                 SRC_DONE;
  logic [BUS_WIDTH-1:0] BUS_DATA;
  logic                 BUS_EN;
  logic                 ACK_ASYNC;

  // master: local producer together with the destination side driving the ack
  modport master (
    output SRC_DATA, SRC_VALID, ACK_ASYNC,
    input  SRC_READY, SRC_DONE, BUS_DATA, BUS_EN
  );

  modport slave (
    input  SRC_DATA, SRC_VALID, ACK_ASYNC,
    output SRC_READY, SRC_DONE, BUS_DATA, BUS_EN
  );

endinterface

// File: rtl/bit_sync.sv
// Single-bit NUM_STAGES-flop synchronizer; output lags input by NUM_STAGES edges.
module bit_sync
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic sync_out
);

  logic [NUM_STAGES-1:0] chain;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chain <= '0;
    end else begin
      chain <= {chain[NUM_STAGES-2:0], async_in};
    end
  end

  assign sync_out = chain[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_src.sv
// Source-side launcher: accepts a word, holds it on the crossing bus, raises BUS_EN a cycle later
// and runs a four-phase handshake on the synchronized ack; not ready again until the ack returns low.
module data_sync_src
  import data_sync_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int MIN_HOLD   = 2
) (
  input  logic           CLK,
  input  logic           RST,
  data_sync_src_if.slave bus
);

  localparam int                HOLD_W    = $clog2(MIN_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);

  sync_state_t          state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [BUS_WIDTH-1:0] bus_data_q, bus_data_d;
  logic                 bus_en_q, bus_en_d;
  logic                 src_done_q, src_done_d;
  logic                 ack_sync;
  logic                 src_ready;

  bit_sync #(
    .NUM_STAGES(NUM_STAGES)
  ) u_ack_sync (
    .CLK      (CLK),
    .RST      (RST),
    .async_in (bus.ACK_ASYNC),
    .sync_out (ack_sync)
  );

  // A lingering ack from the previous transfer must clear before a new word goes out,
  // otherwise ASSERT could exit on the old acknowledge.
  assign src_ready = (state_q == IDLE) && !ack_sync;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      bus_data_q <= '0;
      bus_en_q   <= 1'b0;
      src_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      bus_data_q <= bus_data_d;
      bus_en_q   <= bus_en_d;
      src_done_q <= src_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    bus_data_d = bus_data_q;
    bus_en_d   = 1'b0;
    src_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (src_ready && bus.SRC_VALID) begin
          bus_data_d = bus.SRC_DATA;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        state_d    = ASSERT;
        hold_cnt_d = '0;
        bus_en_d   = 1'b1;
      end
      ASSERT: begin
        if (ack_sync && (hold_cnt_q == HOLD_LAST)) begin
          state_d = RELEASE;
        end else begin
          bus_en_d = 1'b1;
          if (hold_cnt_q != HOLD_LAST) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      RELEASE: begin
        if (!ack_sync) begin
          state_d    = IDLE;
          src_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.SRC_READY = src_ready;
  assign bus.SRC_DONE  = src_done_q;
  assign bus.BUS_DATA  = bus_data_q;
  assign bus.BUS_EN    = bus_en_q;

endmodule

// File: tb/tb_data_sync_src.sv
// Bench for data_sync_src: timeline model of the handshake plus directed scenarios.
module tb_data_sync_src;

  localparam int NS  = 2;
  localparam int MH  = 2;
  localparam int INF = 1 << 30;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  data_sync_src_if #(.BUS_WIDTH(8)) ifc ();
  data_sync_src_if #(.BUS_WIDTH(8)) ifc5 ();

  data_sync_src #(.BUS_WIDTH(8), .NUM_STAGES(NS), .MIN_HOLD(MH)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc)
  );

  data_sync_src #(.BUS_WIDTH(8), .NUM_STAGES(NS), .MIN_HOLD(5)) dut5 (
    .CLK (CLK),
    .RST (RST),
    .bus (ifc5)
  );

  // second instance: always-valid producer with the ack wired straight back
  assign ifc5.SRC_VALID = 1'b1;
  assign ifc5.SRC_DATA  = 8'h5A;
  assign ifc5.ACK_ASYNC = ifc5.BUS_EN;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // destination stand-in: ack follows BUS_EN after ack_dly negedges
  logic       loop_mode = 1'b0;
  logic       ack_force = 1'b0;
  logic [7:0] pipe = 8'h00;
  logic       ack_loop = 1'b0;
  int         ack_dly = 3;
  assign ifc.ACK_ASYNC = loop_mode ? ack_loop : ack_force;

  always @(negedge CLK) begin
    pipe     = {pipe[6:0], ifc.BUS_EN};
    ack_loop = pipe[ack_dly-1];
  end

  // timeline model: per-transfer accept / fall / done edge numbers
  bit         m_busy = 1'b0;
  int         m_acc  = 0;
  int         m_fall = INF;
  int         m_done = -1;
  int         m_k    = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_sync = 1'b0;
  bit         ack_hist[$];

  always @(posedge CLK) begin : model
    bit s_prev;
    if (!RST) begin
      m_busy = 1'b0;
      m_data = 8'h00;
      m_fall = INF;
      m_done = -1;
      m_k    = 0;
      m_sync = 1'b0;
      ack_hist.delete();
    end else begin
      m_k++;
      s_prev = m_sync;
      if (!m_busy) begin
        if (ifc.SRC_VALID && !s_prev) begin
          m_busy = 1'b1;
          m_acc  = m_k;
          m_fall = INF;
          m_data = ifc.SRC_DATA;
        end
      end else if (m_fall == INF) begin
        // enable has been high for (m_k-1-m_acc) cycles so far
        if (s_prev && (m_k - 1 - m_acc) >= MH) m_fall = m_k;
      end else if (!s_prev) begin
        m_busy = 1'b0;
        m_done = m_k;
      end
      ack_hist.push_front(ifc.ACK_ASYNC);
      if (ack_hist.size() > NS) void'(ack_hist.pop_back());
      m_sync = (ack_hist.size() >= NS) ? ack_hist[NS-1] : 1'b0;
    end
  end

  always @(negedge CLK) begin : compare
    if (RST) begin
      check("cmp_ready", int'(ifc.SRC_READY), int'(!m_busy && !m_sync));
      check("cmp_en",    int'(ifc.BUS_EN),    int'(m_busy && (m_k >= m_acc + 1) && (m_k < m_fall)));
      check("cmp_done",  int'(ifc.SRC_DONE),  int'((m_done == m_k) && (m_k > 0)));
      check("cmp_data",  int'(ifc.BUS_DATA),  int'(m_data));
    end
  end

  // event monitor for the main instance and a destination capture queue
  logic       prev_en  = 1'b0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  int         done_cyc = 0;
  int         done_cnt = 0;
  logic [7:0] dest_q[$];

  always @(negedge CLK) begin
    if (!RST) begin
      prev_en = 1'b0;
    end else begin
      if (ifc.BUS_EN && !prev_en) begin
        rise_cyc = cyc;
        dest_q.push_back(ifc.BUS_DATA);
      end
      if (!ifc.BUS_EN && prev_en) fall_cyc = cyc;
      if (ifc.SRC_DONE) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_en = ifc.BUS_EN;
    end
  end

  int w5 = 0;
  int n5 = 0;
  int w5_rec[2];

  always @(negedge CLK) begin
    if (!RST) begin
      w5 = 0;
    end else if (ifc5.BUS_EN) begin
      w5++;
    end else if (w5 > 0) begin
      if (n5 < 2) w5_rec[n5] = w5;
      n5++;
      w5 = 0;
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    for (int i = 0; i < 200 && !ifc.SRC_READY; i++) step();
    check(nm, int'(ifc.SRC_READY), 1);
  endtask

  task automatic wait_done(input int target, input string nm);
    for (int i = 0; i < 200 && done_cnt < target; i++) step();
    check(nm, done_cnt, target);
  endtask

  int d0, t_acc, hi, k;

  initial begin
    w5_rec[0] = 0;
    w5_rec[1] = 0;
    ifc.SRC_VALID = 1'b0;
    ifc.SRC_DATA  = 8'h00;
    repeat (3) step();
    check("rst_ready", int'(ifc.SRC_READY), 1);
    check("rst_en",    int'(ifc.BUS_EN),    0);
    check("rst_done",  int'(ifc.SRC_DONE),  0);
    check("rst_data",  int'(ifc.BUS_DATA),  0);
    RST = 1'b1;

    // single transfer, ack returned three cycles after BUS_EN
    loop_mode = 1'b1;
    ack_dly   = 3;
    step();
    d0 = done_cnt;
    ifc.SRC_DATA  = 8'hA5;
    ifc.SRC_VALID = 1'b1;
    wait_ready("single_ready");
    t_acc = cyc + 1;
    step();
    ifc.SRC_VALID = 1'b0;
    ifc.SRC_DATA  = 8'hFF;
    wait_done(d0 + 1, "single_done");
    repeat (3) step();
    check("single_data_lead", rise_cyc - t_acc, 1);
    check("single_en_width",  fall_cyc - rise_cyc, 5);
    check("single_done_lat",  done_cyc - t_acc, 11);
    check("single_done_once", done_cnt, d0 + 1);
    check("single_data_hold", int'(ifc.BUS_DATA), 8'hA5);

    // back-to-back words with valid held high
    dest_q.delete();
    d0 = done_cnt;
    ifc.SRC_VALID = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      ifc.SRC_DATA = 8'(w);
      wait_ready("b2b_ready");
      step();
    end
    ifc.SRC_VALID = 1'b0;
    wait_done(d0 + 3, "b2b_done");
    step();
    check("b2b_count", dest_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < dest_q.size()) check("b2b_order", int'(dest_q[i]), i + 1);
    end
    check("b2b_last_data", int'(ifc.BUS_DATA), 3);

    // ack never arrives
    loop_mode = 1'b0;
    ack_force = 1'b0;
    d0 = done_cnt;
    ifc.SRC_DATA  = 8'hC3;
    ifc.SRC_VALID = 1'b1;
    wait_ready("noack_ready");
    step();
    ifc.SRC_VALID = 1'b0;
    repeat (100) step();
    check("noack_en",    int'(ifc.BUS_EN),    1);
    check("noack_ready", int'(ifc.SRC_READY), 0);
    check("noack_done",  done_cnt, d0);
    check("noack_data",  int'(ifc.BUS_DATA), 8'hC3);

    // asynchronous reset in the middle of ASSERT
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("midrst_en",    int'(ifc.BUS_EN),    0);
    check("midrst_data",  int'(ifc.BUS_DATA),  0);
    check("midrst_done",  int'(ifc.SRC_DONE),  0);
    check("midrst_ready", int'(ifc.SRC_READY), 1);
    ack_force = 1'b1;
    repeat (2) step();
    RST = 1'b1;

    // stale ack out of reset blocks acceptance
    repeat (3) step();
    check("stale_ready0", int'(ifc.SRC_READY), 0);
    ifc.SRC_DATA  = 8'h3C;
    ifc.SRC_VALID = 1'b1;
    hi = 0;
    repeat (5) begin
      step();
      if (ifc.SRC_READY) hi++;
    end
    check("stale_blocked",   hi, 0);
    check("stale_no_accept", int'(ifc.BUS_DATA), 0);
    ack_force = 1'b0;
    k = 0;
    while (k < 20 && !ifc.SRC_READY) begin
      step();
      k++;
    end
    check("stale_release_lat", k, NS);
    loop_mode = 1'b1;
    d0 = done_cnt;
    step();
    ifc.SRC_VALID = 1'b0;
    wait_done(d0 + 1, "stale_done");
    step();
    check("stale_data", int'(ifc.BUS_DATA), 8'h3C);

    // minimum hold on the looped-back instance
    check("minhold_pulses", int'(n5 >= 2), 1);
    check("minhold_w0", w5_rec[0], 5);
    check("minhold_w1", w5_rec[1], 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
